// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store port: one request at a time,
// serviced from a word-organised RAM after a fixed number of wait states.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] Address,
  input  logic [15:0] WriteData,
  output logic [15:0] ReadData,
  output logic        Ready,
  output logic        AddrError
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [AW-1:0]   idx_reg;
  logic [15:0]     wdata_reg;
  logic            write_reg;
  logic            err_reg;
  logic [15:0]     ram [DEPTH];

  logic            req;
  logic            req_err;
  logic [15:0]     word;
  logic            commit;

  assign req     = MemRead | MemWrite;
  assign word    = {1'b0, Address[15:1]};
  assign req_err = Address[0] | (word >= 16'(DEPTH)) | (MemRead & MemWrite);
  assign commit  = (state_reg == RESP) && !err_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        // A dropped request abandons the transaction before any RAM access.
        if (!req) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg == 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      Ready     <= 1'b0;
      AddrError <= 1'b0;
      ReadData  <= 16'h0000;
      idx_reg   <= '0;
      wdata_reg <= 16'h0000;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      Ready     <= (state_reg == RESP);
      AddrError <= (state_reg == RESP) && err_reg;
      if (state_reg == IDLE && req) begin
        idx_reg   <= Address[AW:1];
        wdata_reg <= WriteData;
        write_reg <= MemWrite;
        err_reg   <= req_err;
      end
      if (commit && !write_reg)
        ReadData <= ram[idx_reg];
    end
  end

  // RAM is never cleared; a reset on the commit edge drops the write.
  always_ff @(posedge Clock) begin
    if (Reset_n && commit && write_reg)
      ram[idx_reg] <= wdata_reg;
  end

endmodule
